perf_counter_bank: RTL and testbench

- Memory-mapped bank of NUM_CNT event counters. It generalises the single cycle counter to configurable width, channel count, wrap or saturate mode, atomic snapshot and sticky overflow flags.
- Channel 0 is the hard-wired cycle counter. Channels 1..NUM_CNT-1 count external event pulses from the core (retired instructions, branch mispredicts, stalls, and so on).
- Sits on the core's MMIO store/load path beside the UART and other IO registers.

---
 rtl/perf_counter_bank_pkg.sv | 32 +++
 rtl/perf_counter_channel.sv | 63 ++++++
 rtl/perf_counter_bank.sv | 142 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the performance counter bank: register map offsets,
// CTRL bit positions and the decoded register selector.
package perf_counter_bank_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0100;

  localparam logic [31:0] OFF_CTRL      = 32'h00;
  localparam logic [31:0] OFF_OVF       = 32'h04;
  localparam logic [31:0] OFF_CNT_BASE  = 32'h10;
  localparam logic [31:0] OFF_SNAP_BASE = 32'h80;
  localparam logic [31:0] OFF_STRIDE    = 32'h08;
  localparam logic [31:0] OFF_HI        = 32'h04;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_CLR_BIT  = 1;
  localparam int CTRL_SNAP_BIT = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_OVF,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_SNAP_LO,
    REG_SNAP_HI
  } reg_sel_e;

  function automatic logic [31:0] chan_off(input logic [31:0] base, input int idx);
    return base + OFF_STRIDE * 32'(idx);
  endfunction

endpackage

// File: rtl/perf_counter_channel.sv
// One counter channel: wrap/saturate counter, sticky W1C overflow flag,
// snapshot register and the HI shadow used for coherent two-word reads.
module perf_counter_channel #(
  parameter int CNT_WIDTH = 48,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_clr,
  input  logic                 i_snap,
  input  logic                 i_ovf_clr,
  input  logic                 i_lo_rd,
  output logic [CNT_WIDTH-1:0]  o_cnt,
  output logic [CNT_WIDTH-1:0]  o_snap,
  output logic [CNT_WIDTH-33:0] o_hi,
  output logic                 o_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  r_snap;
  logic [CNT_WIDTH-33:0] r_hi;
  logic                  r_ovf;
  logic                  w_at_max;

  assign w_at_max = &r_cnt;

  // NOTE: all state here updates with non-blocking assignments so that snap
  // and the HI shadow sample the pre-edge count, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_snap <= '0;
      r_hi   <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (i_clr)
        r_cnt <= '0;
      else if (i_inc && !(w_at_max && SATURATE))
        r_cnt <= r_cnt + CNT_ONE;

      // A cleared cycle loses its event, so it cannot overflow either.
      if (i_inc && w_at_max && !i_clr)
        r_ovf <= 1'b1;
      else if (i_ovf_clr)
        r_ovf <= 1'b0;

      if (i_snap)
        r_snap <= r_cnt;

      if (i_lo_rd)
        r_hi <= r_cnt[CNT_WIDTH-1:32];
    end
  end

  assign o_cnt  = r_cnt;
  assign o_snap = r_snap;
  assign o_hi   = r_hi;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// MMIO bank of event counters: address decode, CTRL/EN register, registered
// read mux and NUM_CNT counter channels (channel 0 counts clock cycles).
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int          NUM_CNT   = 4,
  parameter int          CNT_WIDTH = 48,
  parameter int          SATURATE  = 0,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] events,
  input  logic [31:0]        addr,
  input  logic [3:0]         wbe,
  input  logic [31:0]        wdata,
  input  logic               rd_en,
  output logic [31:0]        rdata,
  output logic               ovf_any
);

  localparam int IDX_W = $clog2(NUM_CNT);

  logic [31:0]          w_off;
  reg_sel_e             w_sel;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_wr;
  logic                 w_ctrl_wr;
  logic                 w_clr;
  logic                 w_snap_req;
  logic [NUM_CNT-1:0]   w_ovf_clr;
  logic [NUM_CNT-1:0]   w_lo_rd;
  logic [NUM_CNT-1:0]   w_inc;
  logic [NUM_CNT-1:0]   w_ovf;
  logic [31:0]          w_rd_val;
  logic                 w_unused;
  logic [CNT_WIDTH-1:0]  w_cnt  [NUM_CNT];
  logic [CNT_WIDTH-1:0]  w_snap [NUM_CNT];
  logic [CNT_WIDTH-33:0] w_hi   [NUM_CNT];

  logic        r_en;
  logic [31:0] r_rdata;

  assign w_off = addr - BASE_ADDR;

  // NOTE: every always_comb output gets a default first, so no path through
  // the decode can leave a signal unassigned and infer a latch.
  always_comb begin
    w_sel = REG_NONE;
    w_idx = '0;
    if (w_off == OFF_CTRL) begin
      w_sel = REG_CTRL;
    end else if (w_off == OFF_OVF) begin
      w_sel = REG_OVF;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_off == chan_off(OFF_CNT_BASE, i)) begin
          w_sel = REG_CNT_LO;
          w_idx = IDX_W'(i);
        end else if (w_off == chan_off(OFF_CNT_BASE, i) + OFF_HI) begin
          w_sel = REG_CNT_HI;
          w_idx = IDX_W'(i);
        end
      end
      // Above 14 channels the CNT window reaches 0x80; SNAP decodes last and wins.
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_off == chan_off(OFF_SNAP_BASE, i)) begin
          w_sel = REG_SNAP_LO;
          w_idx = IDX_W'(i);
        end else if (w_off == chan_off(OFF_SNAP_BASE, i) + OFF_HI) begin
          w_sel = REG_SNAP_HI;
          w_idx = IDX_W'(i);
        end
      end
    end
  end

  assign w_wr       = |wbe;
  assign w_ctrl_wr  = w_wr && (w_sel == REG_CTRL);
  assign w_clr      = w_ctrl_wr && wdata[CTRL_CLR_BIT];
  assign w_snap_req = w_ctrl_wr && wdata[CTRL_SNAP_BIT];
  assign w_ovf_clr  = (w_wr && (w_sel == REG_OVF)) ? wdata[NUM_CNT-1:0] : '0;
  assign w_inc      = {events[NUM_CNT-1:1], 1'b1} & {NUM_CNT{r_en}};
  assign w_unused   = ^{events[0], wdata};

  always_comb begin
    w_lo_rd = '0;
    if (rd_en && (w_sel == REG_CNT_LO))
      w_lo_rd[w_idx] = 1'b1;
  end

  // EN is registered, so a write clearing it still lets that cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_en <= 1'b1;
    else if (w_ctrl_wr)
      r_en <= wdata[CTRL_EN_BIT];
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_ch
    perf_counter_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE != 0)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_inc     (w_inc[g]),
      .i_clr     (w_clr),
      .i_snap    (w_snap_req),
      .i_ovf_clr (w_ovf_clr[g]),
      .i_lo_rd   (w_lo_rd[g]),
      .o_cnt     (w_cnt[g]),
      .o_snap    (w_snap[g]),
      .o_hi      (w_hi[g]),
      .o_ovf     (w_ovf[g])
    );
  end

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      REG_CTRL:    w_rd_val[CTRL_EN_BIT]     = r_en;
      REG_OVF:     w_rd_val[NUM_CNT-1:0]     = w_ovf;
      REG_CNT_LO:  w_rd_val                  = w_cnt[w_idx][31:0];
      REG_CNT_HI:  w_rd_val[CNT_WIDTH-33:0]  = w_hi[w_idx];
      REG_SNAP_LO: w_rd_val                  = w_snap[w_idx][31:0];
      REG_SNAP_HI: w_rd_val[CNT_WIDTH-33:0]  = w_snap[w_idx][CNT_WIDTH-1:32];
      default:     w_rd_val                  = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rdata <= '0;
    else if (rd_en)
      r_rdata <= w_rd_val;
  end

  assign rdata   = r_rdata;
  assign ovf_any = |w_ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default 48-bit wrapping bank plus
// two 33-bit banks (wrap and saturate) sharing the same bus and event inputs.
module tb_perf_counter_bank;

  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk;
  logic        rst;
  logic [3:0]  events;
  logic [31:0] addr;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic        rd_en;
  logic [31:0] rdata_a, rdata_w, rdata_s;
  logic        ovf_a, ovf_w, ovf_s;

  int n_chk = 0;
  int n_err = 0;

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(48), .SATURATE(0), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst), .events(events), .addr(addr), .wbe(wbe), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata_a), .ovf_any(ovf_a));

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(33), .SATURATE(0), .BASE_ADDR(BASE)) dut_w (
    .clk(clk), .rst(rst), .events(events), .addr(addr), .wbe(wbe), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata_w), .ovf_any(ovf_w));

  perf_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(33), .SATURATE(1), .BASE_ADDR(BASE)) dut_s (
    .clk(clk), .rst(rst), .events(events), .addr(addr), .wbe(wbe), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata_s), .ovf_any(ovf_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wbe   = 4'hF;
    tick();
    wbe   = 4'h0;
  endtask

  task automatic pulse(input logic [3:0] ev, input int n);
    repeat (n) begin
      events = ev;
      tick();
      events = '0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; events = '0; addr = '0; wbe = '0; wdata = '0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata_a, 0);
    check("reset_ovf_any", ovf_a, 0);
    rst = 1'b0;

    // Cycle counter: 100 edges after release, the read samples the pre-edge count.
    repeat (100) tick();
    bus_read(BASE + 32'h10);
    check("cycle_cnt_100", rdata_a, 100);
    bus_read(BASE + 32'h18); check("idle_ch1", rdata_a, 0);
    bus_read(BASE + 32'h20); check("idle_ch2", rdata_a, 0);
    bus_read(BASE + 32'h28); check("idle_ch3", rdata_a, 0);
    bus_read(BASE + 32'h00); check("ctrl_en_reset", rdata_a, 1);

    // Snapshot of channel 2 after 7 events, then 3 more live events.
    pulse(4'b0100, 7);
    bus_write(BASE + 32'h00, 32'h5);
    bus_read(BASE + 32'h90); check("snap_lo_ch2", rdata_a, 7);
    bus_read(BASE + 32'h94); check("snap_hi_ch2", rdata_a, 0);
    bus_read(BASE + 32'h88); check("snap_lo_ch1", rdata_a, 0);
    bus_read(BASE + 32'h08); check("unmapped_read", rdata_a, 0);
    pulse(4'b0100, 3);
    bus_read(BASE + 32'h20); check("live_ch2_10", rdata_a, 10);
    bus_read(BASE + 32'h90); check("snap_kept_7", rdata_a, 7);

    // EN=0 written during an event: that cycle counts, the next two do not.
    events = 4'b0100;
    bus_write(BASE + 32'h00, 32'h0);
    tick();
    tick();
    events = '0;
    bus_read(BASE + 32'h20); check("en_off_freeze", rdata_a, 11);
    bus_write(BASE + 32'h00, 32'h1);

    // 33-bit banks: place channel 1 at all-ones.
    force dut_w.g_ch[1].u_ch.r_cnt = 33'h1_FFFF_FFFF;
    force dut_s.g_ch[1].u_ch.r_cnt = 33'h1_FFFF_FFFF;
    #1;
    release dut_w.g_ch[1].u_ch.r_cnt;
    release dut_s.g_ch[1].u_ch.r_cnt;
    bus_read(BASE + 32'h18);
    check("w33_preload_lo", rdata_w, 32'hFFFF_FFFF);
    check("sat_preload_lo", rdata_s, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h1C);
    check("w33_preload_hi", rdata_w, 1);
    check("sat_preload_hi", rdata_s, 1);

    pulse(4'b0010, 1);
    check("w33_ovf_any", ovf_w, 1);
    check("sat_ovf_any", ovf_s, 1);
    check("main_no_ovf", ovf_a, 0);
    bus_read(BASE + 32'h18);
    check("w33_wrap_lo", rdata_w, 0);
    check("sat_hold_lo", rdata_s, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h1C);
    check("w33_wrap_hi", rdata_w, 0);
    check("sat_hold_hi", rdata_s, 1);
    bus_read(BASE + 32'h04);
    check("w33_ovf_reg", rdata_w, 32'h2);
    check("sat_ovf_reg", rdata_s, 32'h2);

    pulse(4'b0010, 4);
    bus_read(BASE + 32'h18);
    check("sat_hold_5", rdata_s, 32'hFFFF_FFFF);
    check("w33_after_wrap", rdata_w, 4);
    bus_read(BASE + 32'h1C);
    check("sat_hold_5_hi", rdata_s, 1);

    bus_write(BASE + 32'h04, 32'h2);
    check("w33_ovf_w1c", ovf_w, 0);
    check("sat_ovf_w1c", ovf_s, 0);
    bus_read(BASE + 32'h04);
    check("sat_ovf_reg_clr", rdata_s, 0);

    // W1C and a new saturating overflow on the same edge: set wins.
    events = 4'b0010;
    bus_write(BASE + 32'h04, 32'h2);
    events = '0;
    check("ovf_set_wins", ovf_s, 1);
    bus_write(BASE + 32'h04, 32'h2);
    check("ovf_cleared_again", ovf_s, 0);

    // Coherent read: LO at 0x0_FFFF_FFFF, carry into bit 32, HI returns shadow.
    force dut_a.g_ch[2].u_ch.r_cnt = 48'h0000_FFFF_FFFF;
    #1;
    release dut_a.g_ch[2].u_ch.r_cnt;
    bus_read(BASE + 32'h20); check("carry_lo_pre", rdata_a, 32'hFFFF_FFFF);
    pulse(4'b0100, 2);
    bus_read(BASE + 32'h24); check("carry_hi_shadow", rdata_a, 0);
    bus_read(BASE + 32'h20); check("carry_lo_post", rdata_a, 1);
    bus_read(BASE + 32'h24); check("carry_hi_fresh", rdata_a, 1);

    // CLR+SNAP in one write while channel 1 has an event.
    bus_read(BASE + 32'h18); check("ch1_pre_clr", rdata_a, 6);
    events = 4'b0010;
    bus_write(BASE + 32'h00, 32'h7);
    events = '0;
    bus_read(BASE + 32'h88); check("snap_pre_clr_ch1", rdata_a, 6);
    bus_read(BASE + 32'h18); check("clr_wins_ch1", rdata_a, 0);
    bus_read(BASE + 32'h90); check("snap_pre_clr_ch2_lo", rdata_a, 1);
    bus_read(BASE + 32'h94); check("snap_pre_clr_ch2_hi", rdata_a, 1);
    bus_read(BASE + 32'h20); check("clr_ch2", rdata_a, 0);

    // Asynchronous reset during a read, with EN off and an overflow pending.
    force dut_w.g_ch[1].u_ch.r_cnt = 33'h1_FFFF_FFFF;
    #1;
    release dut_w.g_ch[1].u_ch.r_cnt;
    pulse(4'b0010, 1);
    check("ovf_before_rst", ovf_w, 1);
    bus_write(BASE + 32'h00, 32'h0);
    bus_read(BASE + 32'h88); check("snap_survives_clr", rdata_a, 6);
    addr  = BASE + 32'h10;
    rd_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_read_rdata", rdata_a, 0);
    check("rst_mid_read_ovf", ovf_w, 0);
    @(negedge clk);
    rd_en = 1'b0;
    rst   = 1'b0;
    bus_read(BASE + 32'h00); check("rst_en_back_1", rdata_a, 1);
    bus_read(BASE + 32'h88); check("rst_snap_cleared", rdata_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
